// File: rtl/spi_fpu_link_if.sv
// rtl/spi_fpu_link_if.sv - command/result handshake bundle between the SPI link and the FPU side
interface spi_fpu_link_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  // link side: issues commands, accepts results
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );

  // FPU side: consumes commands, produces results
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/spi_fpu_link.sv
// rtl/spi_fpu_link.sv - SPI-slave frame link: shifts in {op,a,b}, shifts out the oldest queued FPU result
module spi_fpu_link #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                        SCLK,
  input  logic                        rst,
  input  logic                        CS_N,
  input  logic                        MOSI,
  output logic                        MISO,
  spi_fpu_link_if.master              fpu,
  output logic [$clog2(RESP_DEPTH):0] fifo_level,
  output logic                        overrun
);
  localparam int FRAME_W = OP_W + 2 * DATA_W;
  localparam int PAD_W   = FRAME_W - DATA_W - 3;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int PTR_W   = $clog2(RESP_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENT_W   = DATA_W + 1;

  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0] rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
  logic               miso_q, miso_d;
  logic               vld_sent_q, vld_sent_d;
  logic               ovf_sent_q, ovf_sent_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [OP_W-1:0]    cmd_op_q, cmd_op_d;
  logic [DATA_W-1:0]  cmd_a_q, cmd_a_d;
  logic [DATA_W-1:0]  cmd_b_q, cmd_b_d;
  logic               overrun_q, overrun_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENT_W-1:0]   mem_q [RESP_DEPTH];

  logic               fifo_full, fifo_empty, push, pop;
  logic               frame_bit, frame_done, cmd_take;
  logic [ENT_W-1:0]   head;
  logic [FRAME_W-1:0] rx_frame, tx_word;

  assign fifo_full  = (level_q == LVL_W'(RESP_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign push       = fpu.res_valid && !fifo_full;
  assign rx_frame   = {rx_shift_q, MOSI};

  // An empty FIFO sends a word that is all zero apart from the ovf flag.
  assign tx_word = fifo_empty ? (FRAME_W'(overrun_q) << (FRAME_W - 3))
                              : (FRAME_W'({1'b1, head[DATA_W], overrun_q, head[DATA_W-1:0]}) << PAD_W);

  // A bit only counts once armed, with CS_N low, and before the frame has completed.
  assign frame_bit  = armed_q && !CS_N && (bit_cnt_q < CNT_W'(FRAME_W));
  assign frame_done = frame_bit && (bit_cnt_q == CNT_W'(FRAME_W - 1));
  assign cmd_take   = frame_done && (!cmd_valid_q || fpu.cmd_ready);
  assign pop        = frame_done && vld_sent_q;

  // Next-state for framing, shift registers, command slot, overrun flag and FIFO pointers.
  always_comb begin
    armed_d     = armed_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    vld_sent_d  = vld_sent_q;
    ovf_sent_d  = ovf_sent_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    overrun_d   = overrun_q;

    if (CS_N) begin
      armed_d   = 1'b1;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (frame_bit) begin
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      rx_shift_d = {rx_shift_q[FRAME_W-3:0], MOSI};
      if (bit_cnt_q == '0) begin
        // Head is only peeked here; it is popped at completion so an abort resends it.
        miso_d     = tx_word[FRAME_W-1];
        tx_shift_d = tx_word << 1;
        vld_sent_d = !fifo_empty;
        ovf_sent_d = overrun_q;
      end else begin
        miso_d     = tx_shift_q[FRAME_W-1];
        tx_shift_d = tx_shift_q << 1;
      end
    end else begin
      miso_d = 1'b0;
    end

    if (cmd_valid_q && fpu.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    if (frame_done) begin
      if (cmd_take) begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = rx_frame[FRAME_W-1 -: OP_W];
        cmd_a_d     = rx_frame[2*DATA_W-1 -: DATA_W];
        cmd_b_d     = rx_frame[DATA_W-1:0];
        if (ovf_sent_q) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      vld_sent_q  <= 1'b0;
      ovf_sent_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      vld_sent_q  <= vld_sent_d;
      ovf_sent_q  <= ovf_sent_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Response storage; contents need no reset since level gates every read.
  always_ff @(posedge SCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fpu.res_err, fpu.res_data};
    end
  end

  assign MISO          = miso_q;
  assign fpu.cmd_valid = cmd_valid_q;
  assign fpu.cmd_op    = cmd_op_q;
  assign fpu.cmd_a     = cmd_a_q;
  assign fpu.cmd_b     = cmd_b_q;
  assign fpu.res_ready = !fifo_full;
  assign fifo_level    = level_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_spi_fpu_link.sv
// tb/tb_spi_fpu_link.sv - directed scoreboard bench for spi_fpu_link
module tb_spi_fpu_link;
  logic       SCLK;
  logic       rst;
  logic       CS_N;
  logic       MOSI;
  logic       MISO;
  logic       overrun;
  logic [2:0] fifo_level;

  spi_fpu_link_if #(.DATA_W(32), .OP_W(2)) fpu ();

  spi_fpu_link #(.DATA_W(32), .OP_W(2), .RESP_DEPTH(4)) dut (
    .SCLK       (SCLK),
    .rst        (rst),
    .CS_N       (CS_N),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .fpu        (fpu),
    .fifo_level (fifo_level),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  logic [65:0] exp_cmd_q [$];
  logic [65:0] exp_tx_q  [$];
  logic [32:0] model_res [$];
  logic        model_ovr;
  logic        model_pending;

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of word (MSB first), collecting MISO at each negedge; then idle two cycles.
  task automatic run_frame(input logic [65:0] word, input int nbits, output logic [65:0] obs);
    obs = '0;
    for (int i = 0; i < nbits; i++) begin
      CS_N = 1'b0;
      MOSI = word[65-i];
      @(posedge SCLK);
      @(negedge SCLK);
      obs = {obs[64:0], MISO};
    end
    CS_N = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge SCLK);
  endtask

  function automatic logic [65:0] model_tx_word();
    logic [32:0] h;
    logic        vld;
    vld = (model_res.size() > 0);
    h   = vld ? model_res[0] : 33'h0;
    return {vld, h[32], model_ovr, h[31:0], 31'h0};
  endfunction

  // Full frame with cmd_ready held low; the model decides accept/drop and pop.
  task automatic do_frame(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [65:0] obs;
    logic [65:0] exp_w;
    exp_w = model_tx_word();
    exp_tx_q.push_back(exp_w);
    run_frame({op, a, b}, 66, obs);
    if (model_pending) begin
      model_ovr = 1'b1;
    end else begin
      model_pending = 1'b1;
      exp_cmd_q.push_back({op, a, b});
      if (exp_w[63]) model_ovr = 1'b0;
    end
    if (exp_w[65]) void'(model_res.pop_front());
    chk({tag, "_tx"}, 128'(obs), 128'(exp_tx_q.pop_front()));
    chk({tag, "_lvl"}, 128'(fifo_level), 128'(model_res.size()));
    chk({tag, "_ovr"}, 128'(overrun), 128'(model_ovr));
  endtask

  task automatic abort_frame(input string tag, input logic [65:0] word, input int nbits);
    logic [65:0] obs;
    logic [65:0] exp_w;
    exp_w = model_tx_word();
    run_frame(word, nbits, obs);
    chk({tag, "_tx"}, 128'(obs), 128'(exp_w >> (66 - nbits)));
    chk({tag, "_nocmd"}, 128'(fpu.cmd_valid), 128'(model_pending));
    chk({tag, "_lvl"}, 128'(fifo_level), 128'(model_res.size()));
    chk({tag, "_ovr"}, 128'(overrun), 128'(model_ovr));
  endtask

  // Compare the presented command against the scoreboard, then complete its handshake.
  task automatic check_cmd(input string tag);
    chk({tag, "_cv"}, 128'(fpu.cmd_valid), 128'(1'b1));
    if (exp_cmd_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed command expected none queued", tag);
    end else begin
      chk({tag, "_cmd"}, 128'({fpu.cmd_op, fpu.cmd_a, fpu.cmd_b}), 128'(exp_cmd_q.pop_front()));
    end
    fpu.cmd_ready = 1'b1;
    @(posedge SCLK);
    @(negedge SCLK);
    fpu.cmd_ready = 1'b0;
    model_pending = 1'b0;
    chk({tag, "_cvclr"}, 128'(fpu.cmd_valid), 128'(1'b0));
  endtask

  task automatic push_res(input string tag, input logic [31:0] data, input logic err);
    fpu.res_valid = 1'b1;
    fpu.res_data  = data;
    fpu.res_err   = err;
    chk({tag, "_rdy"}, 128'(fpu.res_ready), 128'(model_res.size() < 4));
    @(posedge SCLK);
    @(negedge SCLK);
    if (model_res.size() < 4) model_res.push_back({err, data});
    fpu.res_valid = 1'b0;
    chk({tag, "_lvl"}, 128'(fifo_level), 128'(model_res.size()));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso"}, 128'(MISO), 128'(1'b0));
    chk({tag, "_cv"}, 128'(fpu.cmd_valid), 128'(1'b0));
    chk({tag, "_cmd"}, 128'({fpu.cmd_op, fpu.cmd_a, fpu.cmd_b}), 128'(0));
    chk({tag, "_rdy"}, 128'(fpu.res_ready), 128'(1'b1));
    chk({tag, "_lvl"}, 128'(fifo_level), 128'(0));
    chk({tag, "_ovr"}, 128'(overrun), 128'(1'b0));
  endtask

  initial begin
    logic [65:0] obs;
    rst           = 1'b1;
    CS_N          = 1'b1;
    MOSI          = 1'b0;
    fpu.cmd_ready = 1'b0;
    fpu.res_valid = 1'b0;
    fpu.res_data  = '0;
    fpu.res_err   = 1'b0;
    model_ovr     = 1'b0;
    model_pending = 1'b0;
    repeat (3) @(negedge SCLK);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge SCLK);

    // 1) empty FIFO, first command
    do_frame("t1", 2'b00, 32'h3F800000, 32'h40000000);
    check_cmd("t1");

    // 2) one result sent and popped
    push_res("t2p", 32'h40400000, 1'b0);
    do_frame("t2", 2'b01, 32'h11111111, 32'h22222222);
    check_cmd("t2");

    // 3) overrun reporting, clearing, and drop priority over clearing
    do_frame("t3a", 2'b10, 32'hAAAA0001, 32'hBBBB0001);
    do_frame("t3b", 2'b11, 32'hAAAA0002, 32'hBBBB0002);
    check_cmd("t3a");
    do_frame("t3c", 2'b00, 32'hAAAA0003, 32'hBBBB0003);
    check_cmd("t3c");
    do_frame("t3d", 2'b01, 32'hAAAA0004, 32'hBBBB0004);
    do_frame("t3e", 2'b10, 32'hAAAA0005, 32'hBBBB0005);
    do_frame("t3f", 2'b11, 32'hAAAA0006, 32'hBBBB0006);
    check_cmd("t3d");
    do_frame("t3g", 2'b00, 32'hAAAA0007, 32'hBBBB0007);
    check_cmd("t3g");

    // 4) abort after 20 bits resends the same head
    push_res("t4p", 32'h12345678, 1'b1);
    abort_frame("t4ab", {2'b11, 32'hDEADBEEF, 32'h01234567}, 20);
    do_frame("t4", 2'b10, 32'h0BADF00D, 32'h76543210);
    check_cmd("t4");

    // 5) fill past depth, then drain in order
    for (int k = 0; k < 5; k++) begin
      push_res($sformatf("t5p%0d", k), 32'hC0DE0000 + 32'(k), k[0]);
    end
    chk("t5_full_rdy", 128'(fpu.res_ready), 128'(1'b0));
    chk("t5_full_lvl", 128'(fifo_level), 128'(4));
    for (int k = 0; k < 5; k++) begin
      do_frame($sformatf("t5f%0d", k), 2'(k), $urandom, $urandom);
      check_cmd($sformatf("t5c%0d", k));
    end

    // 6) reset mid-frame with CS_N held low
    push_res("t6p", 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 30; i++) begin
      CS_N = 1'b0;
      MOSI = i[0];
      @(posedge SCLK);
      @(negedge SCLK);
    end
    rst = 1'b1;
    #1;
    check_reset_vals("t6rst");
    model_res.delete();
    model_ovr     = 1'b0;
    model_pending = 1'b0;
    @(posedge SCLK);
    @(negedge SCLK);
    rst = 1'b0;
    run_frame({2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF}, 36, obs);
    chk("t6_unarmed_miso", 128'(obs), 128'(0));
    chk("t6_unarmed_cv", 128'(fpu.cmd_valid), 128'(1'b0));
    do_frame("t6", 2'b11, 32'h40A00000, 32'h40000000);
    check_cmd("t6");

    chk("cmdq_empty", 128'(exp_cmd_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
